// File: rtl/mem_resp_pkg.sv
// Shared widths, MMIO addresses and FSM state type for the memory responder.
package mem_resp_pkg;
   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;

   localparam logic [ADDR_W-1:0] MMIO_OUT_ADDR = 8'hFF;
   localparam logic [ADDR_W-1:0] MMIO_IN_ADDR  = 8'hFE;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/mem_array.sv
// DEPTH x 8 storage: synchronous write, registered read (read register is resettable,
// storage is not). Addresses at or above DEPTH alias modulo DEPTH.
module mem_array
   import mem_resp_pkg::*;
#(
   parameter int unsigned DEPTH = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IW-1:0]     idx;

   assign idx = IW'(32'(addr) % DEPTH);

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[idx];
      end
   end
endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder (IDLE/WAIT/RESP) in front of mem_array.
// Optional MMIO ports at 8'hFF (io_out) / 8'hFE (io_in) when MEM_RESP_MMIO_EN is defined.
module mem_responder
   import mem_resp_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned DEPTH       = 256
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] io_in,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic [DATA_W-1:0] io_out
);
   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] lat_addr;
   logic              lat_we;
   logic [DATA_W-1:0] lat_wdata;

   logic              capture, enter_resp, rd_fire, wr_fire;
   logic [ADDR_W-1:0] acc_addr;
   logic              acc_we;
   logic              mem_we, mem_re;
   logic [DATA_W-1:0] mem_rdata;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (WAIT_STATES > 0) begin
                  state_d = WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - 4'd1;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         lat_addr  <= '0;
         lat_we    <= 1'b0;
         lat_wdata <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture) begin
            lat_addr  <= addr;
            lat_we    <= we;
            lat_wdata <= wdata;
         end
      end
   end

   // With zero wait states RESP is entered on the sampling edge, so the live inputs
   // (not yet latched) must address the read in IDLE.
   assign capture    = (state_q == IDLE) && req;
   assign acc_addr   = (state_q == IDLE) ? addr : lat_addr;
   assign acc_we     = (state_q == IDLE) ? we   : lat_we;
   assign enter_resp = (state_d == RESP) && (state_q != RESP);
   assign rd_fire    = enter_resp && !acc_we;
   assign wr_fire    = (state_q == RESP) && lat_we;
   assign ready      = (state_q == RESP);

   mem_array #(.DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (acc_addr),
      .wdata (lat_wdata),
      .rdata (mem_rdata)
   );

`ifdef MEM_RESP_MMIO_EN
   logic              acc_mmio;
   logic              mmio_sel;
   logic [DATA_W-1:0] mmio_rdata;
   logic [DATA_W-1:0] io_out_q;

   assign acc_mmio = (acc_addr == MMIO_OUT_ADDR) || (acc_addr == MMIO_IN_ADDR);
   assign mem_re   = rd_fire && !acc_mmio;
   assign mem_we   = wr_fire && !acc_mmio;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mmio_sel   <= 1'b0;
         mmio_rdata <= '0;
         io_out_q   <= '0;
      end else begin
         if (rd_fire) begin
            mmio_sel <= acc_mmio;
            if (acc_addr == MMIO_OUT_ADDR)     mmio_rdata <= io_out_q;
            else if (acc_addr == MMIO_IN_ADDR) mmio_rdata <= io_in;
         end
         if (wr_fire && (lat_addr == MMIO_OUT_ADDR)) io_out_q <= lat_wdata;
      end
   end

   assign rdata  = mmio_sel ? mmio_rdata : mem_rdata;
   assign io_out = io_out_q;
`else
   logic unused_io;

   assign unused_io = ^io_in;
   assign mem_re    = rd_fire;
   assign mem_we    = wr_fire;
   assign rdata     = mem_rdata;
   assign io_out    = '0;
`endif
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: WAIT_STATES, default 1, extra wait cycles per access (legal 0..15).
REQ-002 Parameter: DEPTH, default 256, storage words (8-bit each); addresses >= DEPTH alias modulo DEPTH.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  initiator access request; held high with addr/we/wdata stable until ready.
REQ-006 we  input  1  1 = write, 0 = read.
REQ-007 addr  input  8  word address.
REQ-008 wdata  input  8  write data.
REQ-009 io_in  input  8  external input port, read-only via MMIO.
REQ-010 rdata  output  8  read data, valid when ready=1 and access was a read.
REQ-011 ready  output  1  one-cycle completion strobe.
REQ-012 io_out  output  8  external output port register, written via MMIO.

Function
REQ-013 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-014 IDLE: on edge with req=1, latch addr/we/wdata; go to WAIT if WAIT_STATES>0 (counter loaded WAIT_STATES-1), else RESP.
REQ-015 WAIT: counter decrements each edge; at 0, next edge goes to RESP.
REQ-016 RESP: ready=1 for exactly one cycle; next edge returns to IDLE unconditionally.
REQ-017 Latency: ready asserted WAIT_STATES+1 cycles after the edge that sampled req.
REQ-018 Read: rdata registered on edge entering RESP from latched address; held until next read enters RESP.
REQ-019 Write: storage (or io_out) updated on edge leaving RESP; rdata unchanged by writes.
REQ-020 req changes and input values during WAIT/RESP are ignored; only latched values used.
REQ-021 req still high in cycle after RESP (IDLE) is treated as a new request; back-to-back accesses thus have one idle cycle minimum.
REQ-022 Read-after-write to same address in consecutive transactions returns the newly written value.
REQ-023 ready never asserts without a preceding sampled req.

Reset
REQ-024 reset low: state=IDLE, counter=0, ready=0, rdata=8'h00, io_out=8'h00, latched fields=0, immediately (asynchronous).
REQ-025 Storage contents not cleared by reset; an in-flight write aborted by reset never commits.
REQ-026 First request sampled on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro MEM_RESP_MMIO_EN defined: address 8'hFF write updates io_out (storage untouched), read returns io_out; address 8'hFE read returns io_in sampled on edge entering RESP, write ignored.
REQ-028 MEM_RESP_MMIO_EN undefined: 8'hFE/8'hFF are ordinary storage; io_out tied to 8'h00, io_in unused.

Structure
REQ-029 Package mem_resp_pkg: state enum (IDLE, WAIT, RESP), ADDR_W=8, DATA_W=8, MMIO_OUT_ADDR=8'hFF, MMIO_IN_ADDR=8'hFE.
REQ-030 One sub-module mem_array: synchronous-write, registered-read DEPTH x 8 storage with we/addr/wdata/rdata ports; FSM, counter, and MMIO decode stay in mem_responder.

Verification
REQ-031 WAIT_STATES=1: write 8'hA5 to 8'h10, then read 8'h10 -> ready 2 cycles after each sampled req, rdata=8'hA5.
REQ-032 WAIT_STATES=0: read with req held high 4 cycles -> ready pulses every 2nd cycle, single-cycle width each.
REQ-033 Reset asserted in WAIT during write of 8'h3C to 8'h20 -> ready=0, io_out=0 immediately; later read of 8'h20 returns prior value, not 8'h3C.
REQ-034 MEM_RESP_MMIO_EN: write 8'h5A to 8'hFF -> io_out=8'h5A after RESP edge; io_in=8'hC3, read 8'hFE -> rdata=8'hC3; storage 8'hFF unchanged.
REQ-035 Without MEM_RESP_MMIO_EN: write 8'h77 to 8'hFF then read -> rdata=8'h77, io_out stays 8'h00.
REQ-036 Change addr/wdata mid-WAIT (WAIT_STATES=3) -> access uses values latched at sampling edge.
